// File: rtl/mask_overlay_encoder.sv
// ============================================================================
// Module   : mask_overlay_encoder
// Brief    : Registered pixel slice that paints OVERLAY_RGB over masked pixels,
//            tracks frame position and flags framing errors. Optional per-frame
//            mask pixel counter is enabled by defining MASK_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mask_overlay_encoder #(
   parameter int          IMG_WIDTH   = 640,
   parameter int          IMG_HEIGHT  = 480,
   parameter logic [11:0] OVERLAY_RGB = 12'hF0F
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_sof,
   input  logic [11:0] s_rgb,
   input  logic        s_mask,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [11:0] m_rgb,
   output logic        m_sof,
   output logic        m_eol,
   output logic        frame_err
`ifdef MASK_COUNT_EN
   ,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] mask_count,
   output logic                                      count_valid
`endif
);

   localparam int c_xw = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int c_yw = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [c_xw-1:0] c_x_last = c_xw'(IMG_WIDTH - 1);
   localparam logic [c_yw-1:0] c_y_last = c_yw'(IMG_HEIGHT - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_xw-1:0]   r_x;
   logic [c_yw-1:0]   r_y;
   logic [c_xw-1:0]   w_px;
   logic [c_yw-1:0]   w_py;
   logic              w_out_free;
   logic              w_acc;
   logic              w_fwd;
   logic              w_err;
   logic              w_x_wrap;
   logic              w_last;
   logic              r_m_valid;
   logic [11:0]       r_m_rgb;
   logic              r_m_sof;
   logic              r_m_eol;
   logic              r_frame_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Acceptance also waits on a stalled output in IDLE, so a new frame's first
   // pixel can never overwrite the previous frame's last pixel.
   always_comb begin
      w_state_nxt = r_state;
      w_out_free  = !r_m_valid | m_ready;
      s_ready     = w_out_free;
      w_acc       = s_valid & w_out_free;
      w_fwd       = w_acc & ((r_state == ST_ACTIVE) | s_sof);
      w_err       = w_acc & s_sof & (r_state == ST_ACTIVE) &
                    ((r_x != '0) | (r_y != '0));
      w_px        = s_sof ? '0 : r_x;
      w_py        = s_sof ? '0 : r_y;
      w_x_wrap    = (w_px == c_x_last);
      w_last      = w_x_wrap & (w_py == c_y_last);
      if (w_fwd) begin
         w_state_nxt = w_last ? ST_IDLE : ST_ACTIVE;
      end
   end

   // Counters hold the position of the next pixel; an s_sof pixel is always (0,0).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_fwd) begin
         if (w_last) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_x_wrap) begin
            r_x <= '0;
            r_y <= w_py + c_yw'(1);
         end else begin
            r_x <= w_px + c_xw'(1);
            r_y <= w_py;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_m_valid   <= 1'b0;
         r_m_rgb     <= '0;
         r_m_sof     <= 1'b0;
         r_m_eol     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_err;
         if (w_out_free) begin
            r_m_valid <= w_fwd;
            if (w_fwd) begin
               r_m_rgb <= s_mask ? OVERLAY_RGB : s_rgb;
               r_m_sof <= (w_px == '0) && (w_py == '0);
               r_m_eol <= w_x_wrap;
            end
         end
      end
   end

   assign m_valid   = r_m_valid;
   assign m_rgb     = r_m_rgb;
   assign m_sof     = r_m_sof;
   assign m_eol     = r_m_eol;
   assign frame_err = r_frame_err;

`ifdef MASK_COUNT_EN
   localparam int c_cw = $clog2(IMG_WIDTH*IMG_HEIGHT+1);

   logic [c_cw-1:0] r_acc;
   logic [c_cw-1:0] r_mask_count;
   logic            r_count_valid;

   // A resync closes the old frame without the s_sof pixel, which opens the new one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc         <= '0;
         r_mask_count  <= '0;
         r_count_valid <= 1'b0;
      end else begin
         r_count_valid <= 1'b0;
         if (w_err) begin
            r_mask_count  <= r_acc;
            r_count_valid <= 1'b1;
            r_acc         <= c_cw'(s_mask);
         end else if (w_fwd && w_last) begin
            r_mask_count  <= r_acc + c_cw'(s_mask);
            r_count_valid <= 1'b1;
            r_acc         <= '0;
         end else if (w_fwd) begin
            r_acc <= r_acc + c_cw'(s_mask);
         end
      end
   end

   assign mask_count  = r_mask_count;
   assign count_valid = r_count_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mask_overlay_encoder.sv
// ============================================================================
// Module   : tb_mask_overlay_encoder
// Brief    : Directed and randomized bench for mask_overlay_encoder on a 4x2 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mask_overlay_encoder;

   localparam int          W   = 4;
   localparam int          H   = 2;
   localparam logic [11:0] OVL = 12'hF0F;

   logic        clk;
   logic        resetn;
   logic        s_valid;
   logic        s_ready;
   logic        s_sof;
   logic [11:0] s_rgb;
   logic        s_mask;
   logic        m_valid;
   logic        m_ready;
   logic [11:0] m_rgb;
   logic        m_sof;
   logic        m_eol;
   logic        frame_err;
`ifdef MASK_COUNT_EN
   logic [3:0]  mask_count;
   logic        count_valid;
`endif

   mask_overlay_encoder #(
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .OVERLAY_RGB (OVL)
   ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_sof     (s_sof),
      .s_rgb     (s_rgb),
      .s_mask    (s_mask),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_rgb     (m_rgb),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .frame_err (frame_err)
`ifdef MASK_COUNT_EN
      ,
      .mask_count  (mask_count),
      .count_valid (count_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: expected outputs as a queue of {rgb, sof, eol}.
   logic [13:0] exp_q[$];
   bit          in_frame = 0;
   int          idx      = 0;
   bit          exp_err  = 0;
   int          acc      = 0;
   bit          exp_cv   = 0;
   int          exp_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      in_frame = 0;
      idx      = 0;
      exp_err  = 0;
      acc      = 0;
      exp_cv   = 0;
   endtask

   task automatic model_accept(input logic sof, input logic [11:0] rgb, input logic msk);
      if (sof) begin
         if (in_frame && idx != 0) begin
            exp_err = 1;
            exp_cv  = 1;
            exp_cnt = acc;
            acc     = 0;
         end
         in_frame = 1;
         idx      = 0;
      end
      if (in_frame) begin
         exp_q.push_back({msk ? OVL : rgb, idx == 0, (idx % W) == W - 1});
         acc += int'(msk);
         idx++;
         if (idx == W * H) begin
            in_frame = 0;
            idx      = 0;
            exp_cv   = 1;
            exp_cnt  = acc;
            acc      = 0;
         end
      end
   endtask

   // One clock cycle: check the previous edge's results, drive, then model the next edge.
   task automatic step(input logic v, input logic sof, input logic [11:0] rgb,
                       input logic msk, input logic rdy, output bit accepted);
      logic [13:0] e;
      @(negedge clk);
      check("frame_err", frame_err, exp_err);
      check("m_valid", m_valid, exp_q.size() != 0);
`ifdef MASK_COUNT_EN
      check("count_valid", count_valid, exp_cv);
      if (exp_cv) check("mask_count", mask_count, exp_cnt);
`endif
      exp_err = 0;
      exp_cv  = 0;
      s_valid = v;
      s_sof   = sof;
      s_rgb   = rgb;
      s_mask  = msk;
      m_ready = rdy;
      #1;
      check("s_ready", s_ready, (exp_q.size() == 0) | rdy);
      if (m_valid && m_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("m_rgb", m_rgb, e[13:2]);
         check("m_sof", m_sof, e[1]);
         check("m_eol", m_eol, e[0]);
      end
      accepted = s_valid && s_ready;
      if (accepted) model_accept(sof, rgb, msk);
   endtask

   task automatic check_reset_outputs();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_rgb", m_rgb, 0);
      check("rst_m_sof", m_sof, 0);
      check("rst_m_eol", m_eol, 0);
      check("rst_frame_err", frame_err, 0);
`ifdef MASK_COUNT_EN
      check("rst_mask_count", mask_count, 0);
      check("rst_count_valid", count_valid, 0);
`endif
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      s_valid = 1'b0;
      #2 resetn = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Present one pixel until it is accepted, with a bounded number of attempts.
   task automatic send(input logic sof, input logic [11:0] rgb, input logic msk,
                       input bit toggle_rdy, inout int cyc);
      bit acc_ok = 0;
      for (int t = 0; t < 16 && !acc_ok; t++) begin
         step(1'b1, sof, rgb, msk, toggle_rdy ? ((cyc % 2) == 0) : 1'b1, acc_ok);
         cyc++;
      end
      if (!acc_ok) check("accept_timeout", 0, 1);
   endtask

   initial begin
      logic [7:0] pat;
      bit         a;
      int         cyc;

      resetn  = 1'b0;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_rgb   = '0;
      s_mask  = 1'b0;
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      resetn = 1'b1;

      // 4x2 frame, mask 10100001, no backpressure
      pat = 8'b10100001;
      cyc = 0;
      for (int i = 0; i < 8; i++) send(i == 0, 12'h123, pat[7-i], 0, cyc);
      repeat (2) step(1'b0, 1'b0, 12'h0, 1'b0, 1'b1, a);

      // Pixels without s_sof while idle are discarded
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'h456, i[0], 1'b1, a);

      // Same frame with m_ready toggling 1010...
      cyc = 0;
      for (int i = 0; i < 8; i++) send(i == 0, 12'h123, pat[7-i], 1, cyc);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h0, 1'b0, (i % 2) == 0, a);

      // s_sof on pixel 5 resyncs; seven more pixels complete the new frame
      cyc = 0;
      for (int i = 0; i < 13; i++) send(i == 0 || i == 5, 12'h100 + 12'(i), i[1], 0, cyc);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h777, 1'b1, 1'b1, a);

      // Reset mid-frame, then discard until the next s_sof
      for (int i = 0; i < 3; i++) send(i == 0, 12'hABC, 1'b0, 0, cyc);
      pulse_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h321, 1'b0, 1'b1, a);
      for (int i = 0; i < 8; i++) send(i == 0, 12'h0F0, 1'b0, 0, cyc);

      // Randomized traffic with occasional (sometimes misplaced) s_sof
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(3) != 0, $urandom_range(9) == 0, 12'($urandom_range(4095)),
              $urandom_range(1) == 1, $urandom_range(2) != 0, a);
      end

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h0, 1'b0, 1'b1, a);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mask_overlay_encoder.md
MASK_OVERLAY_ENCODER -- requirements
Module: mask_overlay_encoder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_WIDTH, 640, pixels per row.
- IMG_HEIGHT, 480, rows per frame.
- OVERLAY_RGB, 12'hF0F, RGB444 colour substituted where mask=1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- resetn, in, 1, asynchronous active-low reset.
- s_valid, in, 1, input pixel valid.
- s_ready, out, 1, input pixel accepted when s_valid&s_ready.
- s_sof, in, 1, input pixel is first of frame.
- s_rgb, in, 12, original pixel as {R[3:0],G[3:0],B[3:0]}.
- s_mask, in, 1, binary skin-filter result for the same pixel.
- m_valid, out, 1, output pixel valid.
- m_ready, in, 1, downstream accepts when m_valid&m_ready.
- m_rgb, out, 12, encoded pixel.
- m_sof, out, 1, output pixel is (0,0).
- m_eol, out, 1, output pixel is last of its row.
- frame_err, out, 1, one-cycle pulse on framing error.

Function
REQ-003 The block SHALL be a single-stage registered slice: s_ready = !m_valid | m_ready in ACTIVE; accepted pixel SHALL appear on m_* the next cycle (latency 1).
REQ-004 m_rgb SHALL equal OVERLAY_RGB when the accepted s_mask=1, else s_rgb unchanged.
REQ-005 m_* SHALL hold stable while m_valid=1 and m_ready=0; no pixel SHALL be dropped or duplicated under backpressure.
REQ-006 FSM states: IDLE, ACTIVE. In IDLE s_ready=1; pixels without s_sof SHALL be discarded; accepted s_sof pixel SHALL be forwarded and move to ACTIVE.
REQ-007 Column counter x (0..IMG_WIDTH-1) and row counter y (0..IMG_HEIGHT-1) SHALL advance per accepted pixel; x wraps to 0 and y increments after x=IMG_WIDTH-1.
REQ-008 m_sof SHALL be 1 iff forwarded pixel has x=0,y=0; m_eol SHALL be 1 iff x=IMG_WIDTH-1.
REQ-009 Acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL return FSM to IDLE, counters to 0.
REQ-010 s_sof accepted in ACTIVE at (x,y)≠(0,0): frame_err SHALL pulse 1 cycle, counters SHALL restart so this pixel is (0,0), FSM stays ACTIVE.
REQ-011 s_sof on the last pixel of a frame SHALL be treated per REQ-010 (error, new frame starts).
REQ-012 Counter widths SHALL be $clog2 of the respective parameter; no arithmetic overflow beyond wrap.

Reset
REQ-013 resetn=0 SHALL asynchronously force: FSM=IDLE, x=y=0, m_valid=0, m_rgb=0, m_sof=0, m_eol=0, frame_err=0.
REQ-014 Reset mid-frame SHALL discard the in-flight pixel; after release, pixels are discarded until next s_sof.

Configuration
REQ-015 Macro MASK_COUNT_EN: when defined, SHALL add outputs mask_count (out, $clog2(IMG_WIDTH*IMG_HEIGHT+1)) and count_valid (out, 1); mask_count accumulates accepted s_mask=1 pixels per frame, latches at frame completion (REQ-009) or REQ-010 resync, count_valid pulses 1 cycle then, accumulator clears; both reset to 0.
REQ-016 Without MASK_COUNT_EN these ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-017 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2), m_ready=1, mask pattern 10100001, s_rgb=12'h123 -> m_rgb F0F,123,F0F,123,123,123,123,F0F; m_sof on pixel 0; m_eol on pixels 3,7; FSM IDLE after.
REQ-018 Same frame, m_ready toggling 1010... -> identical output sequence, no loss, m_* stable while stalled.
REQ-019 Pixels without s_sof in IDLE -> m_valid stays 0, s_ready=1.
REQ-020 s_sof asserted on pixel 5 -> frame_err pulse once, that pixel emitted with m_sof=1, next 7 pixels form full frame.
REQ-021 resetn low mid-frame for 1 cycle -> m_valid=0 immediately; no output until next s_sof.
REQ-022 MASK_COUNT_EN defined, REQ-017 frame -> count_valid pulse, mask_count=3; next frame all-zero mask -> mask_count=0.
